// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like arbiter: data side has fixed priority, an in-order ID FIFO routes responses.
// Optional feature macro ARB_INST_CANCEL_EN: inst_cancel marks pending inst responses as discarded.
module sram_like_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [DEPTH-1:0] id_mem;
  logic             use_data;
  logic             sel_req;
  logic             full;
  logic             push;
  logic             pop;
  logic             head_id;
  logic             head_disc;
  logic             cancel;

  // A lock pins the grant to one side so its payload stays stable across addr_ok stalls.
  assign use_data = (state == LOCK_D) || ((state == IDLE) && data_req);
  assign sel_req  = use_data ? data_req : inst_req;
  assign full     = (count == (PW+1)'(DEPTH));

  assign mem_req   = sel_req && !full && !reset;
  assign mem_wr    = use_data ? data_wr    : inst_wr;
  assign mem_size  = use_data ? data_size  : inst_size;
  assign mem_addr  = use_data ? data_addr  : inst_addr;
  assign mem_wdata = use_data ? data_wdata : inst_wdata;

  assign push         = mem_req && mem_addr_ok;
  assign data_addr_ok = push && use_data;
  assign inst_addr_ok = push && !use_data;

  // A data_ok with nothing outstanding is a protocol error and is dropped here.
  assign pop          = mem_data_ok && (count != '0) && !reset;
  assign head_id      = id_mem[rd_ptr];
  assign data_data_ok = pop && head_id;
  assign inst_data_ok = pop && !head_id && !head_disc;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign busy         = (count != '0) && !reset;

`ifdef ARB_INST_CANCEL_EN
  logic [DEPTH-1:0] disc_mem;
  logic [DEPTH-1:0] entry_valid;

  assign cancel    = inst_cancel;
  assign head_disc = disc_mem[rd_ptr];

  always_comb begin
    logic [PW-1:0] offset;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count);
    end
  end

  // The push write comes last so an inst entry accepted alongside a cancel is discarded too.
  always_ff @(posedge clk) begin
    if (reset) begin
      disc_mem <= '0;
    end else begin
      if (cancel) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entry_valid[i] && !id_mem[i]) disc_mem[i] <= 1'b1;
        end
      end
      if (push) disc_mem[wr_ptr] <= cancel && !use_data;
    end
  end
`else
  logic unused_cancel;

  assign unused_cancel = inst_cancel;
  assign cancel        = 1'b0;
  assign head_disc     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_req && !mem_addr_ok) state_next = use_data ? LOCK_D : LOCK_I;
      LOCK_I:  if (push || !inst_req || cancel) state_next = IDLE;
      LOCK_D:  if (push || !data_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      id_mem <= '0;
    end else begin
      state <= state_next;
      if (push) begin
        id_mem[wr_ptr] <= use_data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule
